instr_fetch_unit: RTL and testbench

- Producer of the 32-bit `instruction` word consumed by the MIPS datapath/control.
- Holds the PC and issues word reads to an instruction memory with variable latency.
- Buffers the returned words with their PC in an in-order FIFO and hands them to the core over a valid/ready handshake.
- Supports redirects (branch/jump) that flush stale words.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and PC constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_STOPPED} state_t;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order buffer of {pc, word} entries with a registered head that holds when empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [63:0]      i_data,
  output logic [CNT_W-1:0] o_count,
  output logic [63:0]      o_head
);
  localparam int PW = $clog2(DEPTH);
  logic [63:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_head;
  logic             w_push, w_pop;
  logic [PW-1:0]    w_rd_nxt;
  assign w_pop    = i_pop && (r_count != '0);
  assign w_push   = i_push && !i_flush && (r_count != CNT_W'(DEPTH));
  assign w_rd_nxt = r_rd + PW'(1);
  assign o_count  = r_count;
  assign o_head   = r_head;
  // entry storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
  // pointers, occupancy and the head register; head only moves when a new entry becomes the head
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= w_rd_nxt;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_pop && r_count > CNT_W'(1)) r_head <= r_mem[w_rd_nxt];
      else if (w_push && (r_count == '0 || (w_pop && r_count == CNT_W'(1)))) r_head <= i_data;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing, credit-limited imem requests, stale-response discard and output buffering
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fetch_en,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_instr_pc
);
  localparam logic [CNT_W:0] L_DEPTH = FIFO_DEPTH[CNT_W:0];
  state_t           r_state, w_state_nxt;
  logic [31:0]      r_pc, r_rsp_pc, w_redir_pc;
  logic [CNT_W-1:0] r_out, r_discard, w_count;
  logic [CNT_W:0]   w_credit;
  logic [63:0]      w_head;
  logic             w_redir, w_grant, w_rsp, w_push, w_pop;
  assign w_redir       = i_redirect && (r_state != ST_BOOT);
  assign w_redir_pc    = i_redirect_pc & ~32'h3;
  assign w_credit      = {1'b0, r_out} + {1'b0, w_count};
  assign o_imem_req    = (r_state == ST_RUN) && !i_redirect && (w_credit < L_DEPTH);
  assign o_imem_addr   = r_pc;
  assign w_grant       = o_imem_req && i_imem_gnt;
  assign w_rsp         = i_imem_rvalid && (r_out != '0);
  assign w_push        = w_rsp && (r_discard == '0) && !w_redir;
  assign o_instr_valid = (w_count != '0);
  assign w_pop         = o_instr_valid && i_instr_ready;
  assign o_instruction = w_head[31:0];
  assign o_instr_pc    = w_head[63:32];
  // next state: a single boot cycle, then run or stop as fetch_en dictates
  always_comb begin
    w_state_nxt = ST_RUN;
    if (r_state != ST_BOOT && !i_fetch_en) w_state_nxt = ST_STOPPED;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_BOOT;
    else r_state <= w_state_nxt;
  end
  // fetch/response PCs and in-flight accounting; a redirect marks every live request as stale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_rsp_pc  <= RESET_PC;
      r_out     <= '0;
      r_discard <= '0;
    end else begin
      r_out <= r_out + CNT_W'(w_grant) - CNT_W'(w_rsp);
      if (w_redir) begin
        r_pc      <= w_redir_pc;
        r_rsp_pc  <= w_redir_pc;
        r_discard <= r_out - CNT_W'(w_rsp);
      end else begin
        if (w_grant) r_pc <= r_pc + PC_INC;
        if (w_push) r_rsp_pc <= r_rsp_pc + PC_INC;
        if (w_rsp && r_discard != '0) r_discard <= r_discard - CNT_W'(1);
      end
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  ({r_rsp_pc, i_imem_rdata}),
    .o_count (w_count),
    .o_head  (w_head)
  );
  ap_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n) !(i_imem_rvalid && r_out == '0))
    else $error("imem_rvalid with no outstanding request");
  ap_push_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_count == L_DEPTH[CNT_W-1:0]))
    else $error("push into a full fetch buffer");
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors and corner-case sequences for the fetch unit
module tb_instr_fetch_unit;
  logic        clk = 1'b0, rst_n = 1'b0, i_fetch_en = 1'b0, i_redirect = 1'b0;
  logic        i_imem_gnt = 1'b1, i_imem_rvalid = 1'b0, i_instr_ready = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0, i_imem_rdata = 32'h0;
  logic        o_imem_req, o_instr_valid;
  logic [31:0] o_imem_addr, o_instruction, o_instr_pc;
  int          tests = 0, fails = 0, stale = 0;
  logic [31:0] lat = 32'd1, cyc = 32'd0;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } pend_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] word; } del_t;
  typedef struct { logic fe, rdy, req; logic [31:0] addr; logic vld; logic [31:0] pc, ins; } vec_t;
  pend_t       pq[$];
  del_t        dq[$];
  logic [31:0] gq[$];
  vec_t        tv[13];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_fetch_en    (i_fetch_en),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instruction (o_instruction),
    .o_instr_pc    (o_instr_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] dq_pc(input int k);
    return (k < dq.size()) ? dq[k].pc : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] dq_word(input int k);
    return (k < dq.size()) ? dq[k].word : 32'hBAD0_BAD0;
  endfunction

  // memory model and monitors: sample pre-edge values of grants, responses and handoffs
  always @(posedge clk) begin
    if (i_imem_rvalid) void'(pq.pop_front());
    if (o_imem_req && i_imem_gnt) begin
      pq.push_back('{o_imem_addr, cyc + lat});
      gq.push_back(o_imem_addr);
    end
    if (rst_n && o_instr_valid && i_instr_ready) dq.push_back('{o_instr_pc, o_instruction});
    cyc <= cyc + 32'd1;
  end

  // return in-order responses once their latency has elapsed
  always @(negedge clk) begin
    i_imem_rvalid = (pq.size() != 0) && (pq[0].due <= cyc);
    i_imem_rdata  = i_imem_rvalid ? mem_word(pq[0].addr) : 32'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] l, input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    i_redirect = 1'b0;
    i_fetch_en = 1'b1;
    i_instr_ready = rdy;
    repeat (5) @(negedge clk);
    lat = l;
    dq.delete();
    gq.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //        fe    rdy   req   addr           vld   pc             instruction
    tv[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0000};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'hDEAD_0000};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'hDEAD_0004};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0004, 32'hDEAD_0004};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'hDEAD_0008};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'hDEAD_000C};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C, 32'hDEAD_000C};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C, 32'hDEAD_000C};
    tv[10] = '{1'b1, 1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C, 32'hDEAD_000C};
    tv[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010, 32'hDEAD_0010};
    tv[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_0018, 1'b0, 32'h0000_0010, 32'hDEAD_0010};
    i_fetch_en = 1'b1;
    i_instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      i_fetch_en = tv[i].fe;
      i_instr_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d req", i), 32'(o_imem_req), 32'(tv[i].req));
      chk($sformatf("v%0d addr", i), o_imem_addr, tv[i].addr);
      chk($sformatf("v%0d valid", i), 32'(o_instr_valid), 32'(tv[i].vld));
      chk($sformatf("v%0d pc", i), o_instr_pc, tv[i].pc);
      chk($sformatf("v%0d instr", i), o_instruction, tv[i].ins);
    end

    // redirect with two requests in flight, 3-cycle memory
    do_reset(32'd3, 1'b1);
    #1 chk("R boot req", 32'(o_imem_req), 32'd0);
    repeat (3) @(negedge clk);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0103;
    #1;
    chk("R grants before", 32'(gq.size()), 32'd2);
    chk("R req in redirect", 32'(o_imem_req), 32'd0);
    @(negedge clk);
    i_redirect = 1'b0;
    #1;
    chk("R flushed valid", 32'(o_instr_valid), 32'd0);
    chk("R new addr", o_imem_addr, 32'h0000_0100);
    repeat (12) @(negedge clk);
    chk("R pc0", dq_pc(0), 32'h0000_0100);
    chk("R word0", dq_word(0), 32'hDEAD_0100);
    chk("R pc1", dq_pc(1), 32'h0000_0104);
    chk("R pc2", dq_pc(2), 32'h0000_0108);
    chk("R word2", dq_word(2), 32'hDEAD_0108);
    stale = 0;
    foreach (dq[k]) if (dq[k].pc < 32'h0000_0100) stale++;
    chk("R stale words", 32'(stale), 32'd0);

    // redirect, response and pop in the same cycle with one outstanding
    do_reset(32'd1, 1'b1);
    repeat (3) @(negedge clk);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    #1;
    chk("S valid at redirect", 32'(o_instr_valid), 32'd1);
    chk("S pc at redirect", o_instr_pc, 32'h0000_0000);
    chk("S req at redirect", 32'(o_imem_req), 32'd0);
    @(negedge clk);
    i_redirect = 1'b0;
    #1;
    chk("S valid after", 32'(o_instr_valid), 32'd0);
    chk("S req after", 32'(o_imem_req), 32'd1);
    chk("S addr after", o_imem_addr, 32'h0000_0200);
    repeat (2) @(negedge clk);
    #1;
    chk("S new valid", 32'(o_instr_valid), 32'd1);
    chk("S new pc", o_instr_pc, 32'h0000_0200);
    chk("S new instr", o_instruction, 32'hDEAD_0200);
    @(negedge clk);
    chk("S popped pc", dq_pc(0), 32'h0000_0000);
    chk("S popped word", dq_word(0), 32'hDEAD_0000);
    chk("S next pc", dq_pc(1), 32'h0000_0200);

    // boot-cycle redirect ignored, fetch_en gating, PC wrap, 2-cycle memory
    do_reset(32'd2, 1'b1);
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0500;
    #1 chk("W boot req", 32'(o_imem_req), 32'd0);
    @(negedge clk);
    i_redirect_pc = 32'hFFFF_FFFB;
    #1;
    chk("W boot redirect ignored", o_imem_addr, 32'h0000_0000);
    chk("W req in redirect", 32'(o_imem_req), 32'd0);
    @(negedge clk);
    i_redirect = 1'b0;
    #1;
    chk("W req fff8", 32'(o_imem_req), 32'd1);
    chk("W addr fff8", o_imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    #1 chk("W addr fffc", o_imem_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_fetch_en = 1'b0;
      #1 chk($sformatf("W stopped req %0d", i), 32'(o_imem_req), 32'd0);
    end
    chk("W drained while stopped", 32'(dq.size()), 32'd2);
    chk("W pc0", dq_pc(0), 32'hFFFF_FFF8);
    chk("W word0", dq_word(0), 32'h2152_FFF8);
    chk("W pc1", dq_pc(1), 32'hFFFF_FFFC);
    @(negedge clk);
    i_fetch_en = 1'b1;
    #1 chk("W req while still stopped", 32'(o_imem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("W req resume", 32'(o_imem_req), 32'd1);
    chk("W wrap addr", o_imem_addr, 32'h0000_0000);
    repeat (4) @(negedge clk);
    chk("W wrap pc", dq_pc(2), 32'h0000_0000);
    chk("W wrap word", dq_word(2), 32'hDEAD_0000);

    // reset mid-flight: one word buffered, one outstanding, late response during reset
    do_reset(32'd3, 1'b0);
    @(negedge clk);
    #1 chk("M addr0", o_imem_addr, 32'h0000_0000);
    @(negedge clk);
    lat = 32'd5;
    #1 chk("M addr4", o_imem_addr, 32'h0000_0004);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("M head before reset", 32'(o_instr_valid), 32'd1);
    chk("M head pc before reset", o_instr_pc, 32'h0000_0000);
    @(negedge clk);
    #1;
    chk("M valid after reset", 32'(o_instr_valid), 32'd0);
    chk("M req after reset", 32'(o_imem_req), 32'd0);
    chk("M pc after reset", o_instr_pc, 32'h0000_0000);
    repeat (4) @(negedge clk);
    lat = 32'd1;
    i_instr_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("M boot req", 32'(o_imem_req), 32'd0);
    chk("M boot valid", 32'(o_instr_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("M restart req", 32'(o_imem_req), 32'd1);
    chk("M restart addr", o_imem_addr, 32'h0000_0000);
    repeat (3) @(negedge clk);
    chk("M first pc", dq_pc(0), 32'h0000_0000);
    chk("M first word", dq_word(0), 32'hDEAD_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
